// File: rtl/magic_pkg.sv
// magic_pkg
// Shared types for the MAGIC NOR sequencer: micro-op encoding, the packed
// instruction word, FSM states and width helper functions.
// No ports (package).
package magic_pkg;

  localparam int MAGIC_NUM_IN     = 8;
  localparam int MAGIC_NUM_CELLS  = 32;
  localparam int MAGIC_PROG_DEPTH = 32;

  // Address width for a power-of-two sized array (minimum 1 bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Instruction width: 2-bit opcode plus three cell addresses.
  function automatic int instr_width(input int num_cells);
    return 2 + 3 * addr_width(num_cells);
  endfunction

  localparam int CELL_W = addr_width(MAGIC_NUM_CELLS);

  typedef enum logic [1:0] {
    OP_NOR2 = 2'b00,
    OP_NOT  = 2'b01,
    OP_HALT = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [CELL_W-1:0] dst;
    logic [CELL_W-1:0] src_a;
    logic [CELL_W-1:0] src_b;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/magic_nor_sequencer_prog_mem.sv
// magic_prog_mem
// Micro-op program store: PROG_DEPTH x instr_t, synchronous write,
// asynchronous read, deliberately not reset so a program survives rst.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - instruction to store
//   raddr  - read address (combinational)
//   rdata  - instruction at raddr
module magic_prog_mem
  import magic_pkg::*;
#(
  parameter int PROG_DEPTH = MAGIC_PROG_DEPTH,
  localparam int PW = addr_width(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  instr_t        wdata,
  input  logic [PW-1:0] raddr,
  output instr_t        rdata
);

  instr_t mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer
// Executes a NOR/NOT micro-op program over a bank of 1-bit cells, one op per
// cycle, mimicking a MAGIC memristor row: a cell can only be pulled 1->0 by
// an op, so every gate output cell must start at 1.
// The instruction layout follows instr_t, whose cell-address width comes from
// the package cell count; NUM_CELLS must match MAGIC_NUM_CELLS.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   prog_we/addr/data     - program write port, honoured only in IDLE
//   in_valid/ready/data   - input vector handshake, bit i loads cell i
//   out_valid/ready       - result handshake
//   out_data              - result bit
//   out_err               - program ran past the last address without HALT
//   busy                  - high whenever not IDLE
module magic_nor_sequencer
  import magic_pkg::*;
#(
  parameter int NUM_IN     = MAGIC_NUM_IN,
  parameter int NUM_CELLS  = MAGIC_NUM_CELLS,
  parameter int PROG_DEPTH = MAGIC_PROG_DEPTH,
  localparam int CW = addr_width(NUM_CELLS),
  localparam int PW = addr_width(PROG_DEPTH),
  localparam int IW = 2 + 3 * CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic              out_err,
  output logic              busy
);

  localparam logic [PW-1:0] LAST_PC = PW'(PROG_DEPTH - 1);

  state_e                state;
  logic [PW-1:0]         pc;
  logic [NUM_CELLS-1:0]  cells;
  logic [NUM_IN-1:0]     in_buf;
  instr_t                instr;
  logic                  mem_we;
  logic                  a_bit;
  logic                  b_bit;
  logic                  dst_bit;
  logic                  gate_val;

  // Programming is locked out while a vector is in flight.
  assign mem_we = prog_we && (state == IDLE);

  magic_prog_mem #(
    .PROG_DEPTH(PROG_DEPTH)
  ) u_prog_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(instr_t'(prog_data)),
    .raddr(pc),
    .rdata(instr)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // MAGIC gate evaluation: the destination is ANDed with the NOR result, so
  // a cell already at 0 stays 0. Operands are the pre-update cell values,
  // which makes dst == src_a refer to the old value.
  always_comb begin
    a_bit    = cells[instr.src_a];
    b_bit    = cells[instr.src_b];
    dst_bit  = cells[instr.dst];
    gate_val = dst_bit;
    case (instr.op)
      OP_NOR2: gate_val = dst_bit & ~(a_bit | b_bit);
      OP_NOT:  gate_val = dst_bit & ~a_bit;
      default: gate_val = dst_bit;
    endcase
  end

  // Sequencer FSM: capture vector, initialise the cell row, step the
  // program until HALT or the last address, then hold the result until it
  // is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      cells    <= '1;
      in_buf   <= '0;
      out_data <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_buf <= in_data;
            state  <= LOAD;
          end
        end
        LOAD: begin
          cells <= {{(NUM_CELLS - NUM_IN){1'b1}}, in_buf};
          pc    <= '0;
          state <= EXEC;
        end
        EXEC: begin
          cells[instr.dst] <= gate_val;
          if (instr.op == OP_HALT) begin
            out_data <= a_bit;
            out_err  <= 1'b0;
            state    <= DONE;
          end else if (pc == LAST_PC) begin
            // Ran off the end without HALT: no wrap, flag the error.
            out_data <= 1'b0;
            out_err  <= 1'b1;
            state    <= DONE;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// tb_magic_nor_sequencer
// Self-checking bench for magic_nor_sequencer: directed scenarios plus
// random programs compared against a sequential interpreter of the op rules.
module tb_magic_nor_sequencer;

  localparam int NUM_IN     = 8;
  localparam int NUM_CELLS  = 32;
  localparam int PROG_DEPTH = 32;
  localparam int PW         = 5;
  localparam int IW         = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [PW-1:0]     prog_addr;
  logic [IW-1:0]     prog_data;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_IN-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_data;
  logic              out_err;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench copy of what the program memory is supposed to hold.
  logic [IW-1:0] prog [PROG_DEPTH];

  always #5 clk = ~clk;

  magic_nor_sequencer #(
    .NUM_IN(NUM_IN),
    .NUM_CELLS(NUM_CELLS),
    .PROG_DEPTH(PROG_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_err(out_err),
    .busy(busy)
  );

  function automatic logic [IW-1:0] mk(input int op, input int dst, input int a, input int b);
    return {op[1:0], dst[4:0], a[4:0], b[4:0]};
  endfunction

  // Reference interpreter: walk the program in order over an array of bits.
  function automatic void model(input logic [7:0] din, output logic res,
                                output logic err, output int lat);
    logic c [NUM_CELLS];
    int d, a, b;
    for (int i = 0; i < NUM_CELLS; i++) c[i] = (i < NUM_IN) ? din[i] : 1'b1;
    res = 1'b0;
    err = 1'b1;
    lat = PROG_DEPTH + 2;
    for (int p = 0; p < PROG_DEPTH; p++) begin
      d = 32'(prog[p][14:10]);
      a = 32'(prog[p][9:5]);
      b = 32'(prog[p][4:0]);
      case (prog[p][16:15])
        2'b00: c[d] = c[d] & ~(c[a] | c[b]);
        2'b01: c[d] = c[d] & ~c[a];
        2'b10: begin res = c[a]; err = 1'b0; lat = p + 3; return; end
        default: ;
      endcase
    end
  endfunction

  task automatic write_instr(input int addr, input logic [IW-1:0] ins);
    prog_we   = 1'b1;
    prog_addr = addr[4:0];
    prog_data = ins;
    @(posedge clk); #1;
    prog_we = 1'b0;
    prog[addr] = ins;
  endtask

  task automatic write_all;
    for (int i = 0; i < PROG_DEPTH; i++) write_instr(i, prog[i]);
  endtask

  // rd84f3: AND of all eight inputs built from NOR/NOT only.
  task automatic load_rd84;
    for (int i = 0; i < PROG_DEPTH; i++) prog[i] = mk(3, 0, 0, 0);
    for (int i = 0; i < 8; i++) prog[i] = mk(1, 8 + i, i, 0);
    for (int i = 0; i < 4; i++) prog[8 + i] = mk(0, 16 + i, 8 + 2 * i, 9 + 2 * i);
    for (int i = 0; i < 4; i++) prog[12 + i] = mk(1, 20 + i, 16 + i, 0);
    prog[16] = mk(0, 24, 20, 21);
    prog[17] = mk(0, 25, 22, 23);
    prog[18] = mk(1, 26, 24, 0);
    prog[19] = mk(1, 27, 25, 0);
    prog[20] = mk(0, 28, 26, 27);
    prog[21] = mk(2, 0, 28, 0);
    write_all();
  endtask

  // Sends one vector (optionally with a same-edge program write), waits for
  // the result, counts edges from the accepting edge and consumes it.
  task automatic run_vector(input logic [7:0] din, input logic we_en, input int we_addr,
                            input logic [IW-1:0] we_data, output int lat, output logic od,
                            output logic oe, output logic rb, output logic pb);
    in_valid  = 1'b1;
    in_data   = din;
    prog_we   = we_en;
    prog_addr = we_addr[4:0];
    prog_data = we_data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prog_we  = 1'b0;
    lat = 1;
    rb  = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) rb = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    od = out_data;
    oe = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pb = (in_ready !== 1'b1) || (out_valid !== 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, out_data, out_err} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset: got rdy=%b vld=%b busy=%b data=%b err=%b, expected 1 0 0 0 0",
               in_ready, out_valid, busy, out_data, out_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rd84f3;
    logic [7:0] vecs [4];
    logic       exp_d [4];
    int lat;
    logic od, oe, rb, pb;
    vecs[0] = 8'hFF; exp_d[0] = 1'b1;
    vecs[1] = 8'hFE; exp_d[1] = 1'b0;
    vecs[2] = 8'h7F; exp_d[2] = 1'b0;
    vecs[3] = 8'h00; exp_d[3] = 1'b0;
    load_rd84();
    for (int i = 0; i < 4; i++) begin
      run_vector(vecs[i], 1'b0, 0, '0, lat, od, oe, rb, pb);
      n_cmp++;
      if (lat != 24 || od !== exp_d[i] || oe !== 1'b0 || rb !== 1'b0 || pb !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rd84f3 in=%h: got lat=%0d data=%b err=%b rdy_in_run=%b post=%b, expected lat=24 data=%b err=0 rdy_in_run=0 post=0",
                 vecs[i], lat, od, oe, rb, pb, exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int hits, pos1, pos2;
    logic d1, d2;
    hits = 0; pos1 = -1; pos2 = -1; d1 = 1'b0; d2 = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_data = 8'hFE;
      if (k == 26) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        hits++;
        if (hits == 1) begin pos1 = k; d1 = out_data; end
        else if (hits == 2) begin pos2 = k; d2 = out_data; end
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (hits != 2 || pos1 != 24 || pos2 != 49 || d1 !== 1'b1 || d2 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL back_to_back: got hits=%0d at %0d,%0d data=%b,%b, expected hits=2 at 24,49 data=1,0",
               hits, pos1, pos2, d1, d2);
    end
  endtask

  task automatic test_backpressure;
    int w;
    logic bad, extra;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
      if (out_valid !== 1'b1 || out_data !== 1'b1 || out_err !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    if (out_valid !== 1'b1 || out_data !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL backpressure_hold: got unstable=%b, expected unstable=0", bad);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    extra = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL backpressure_single: got extra_activity=%b, expected 0", extra);
    end
  endtask

  task automatic test_runaway;
    int lat;
    logic od, oe, rb, pb;
    for (int i = 0; i < PROG_DEPTH; i++) prog[i] = mk(3, 0, 0, 0);
    write_all();
    run_vector(8'hA5, 1'b0, 0, '0, lat, od, oe, rb, pb);
    n_cmp++;
    if (lat != PROG_DEPTH + 2 || od !== 1'b0 || oe !== 1'b1 || rb !== 1'b0 || pb !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL runaway: got lat=%0d data=%b err=%b rdy_in_run=%b post=%b, expected lat=%0d data=0 err=1 rdy_in_run=0 post=0",
               lat, od, oe, rb, pb, PROG_DEPTH + 2);
    end
  endtask

  task automatic test_magic_init;
    int lat;
    logic od, oe, rb, pb;
    // Both NORs see zero sources: cell 9 keeps its init 1.
    write_instr(0, mk(0, 9, 0, 1));
    write_instr(1, mk(0, 9, 0, 0));
    write_instr(2, mk(2, 0, 9, 0));
    run_vector(8'h00, 1'b0, 0, '0, lat, od, oe, rb, pb);
    n_cmp++;
    if (lat != 5 || od !== 1'b1 || oe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL magic_keep: got lat=%0d data=%b err=%b, expected lat=5 data=1 err=0", lat, od, oe);
    end
    // Source 0 is 1 here: cell 9 drops to 0 and an all-zero NOR cannot restore it.
    write_instr(1, mk(0, 9, 2, 3));
    run_vector(8'h01, 1'b0, 0, '0, lat, od, oe, rb, pb);
    n_cmp++;
    if (lat != 5 || od !== 1'b0 || oe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL magic_sticky: got lat=%0d data=%b err=%b, expected lat=5 data=0 err=0", lat, od, oe);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic od, oe, rb, pb, seen;
    load_rd84();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_async: got busy=%b rdy=%b vld=%b, expected 0 1 0", busy, in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_drop: got out_valid_seen=%b, expected 0", seen);
    end
    run_vector(8'hFF, 1'b0, 0, '0, lat, od, oe, rb, pb);
    n_cmp++;
    if (lat != 24 || od !== 1'b1 || oe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_rerun: got lat=%0d data=%b err=%b, expected lat=24 data=1 err=0", lat, od, oe);
    end
  endtask

  task automatic test_prog_guard;
    int lat;
    logic od, oe, rb, pb;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 5'd3;
    prog_data = mk(2, 0, 8, 0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 12) prog_we = 1'b0;
    end
    prog_we = 1'b0;
    od = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (lat != 24 || od !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL prog_guard_run: got lat=%0d data=%b, expected lat=24 data=1", lat, od);
    end
    run_vector(8'hFF, 1'b0, 0, '0, lat, od, oe, rb, pb);
    n_cmp++;
    if (lat != 24 || od !== 1'b1 || oe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL prog_guard_mem: got lat=%0d data=%b err=%b, expected lat=24 data=1 err=0", lat, od, oe);
    end
  endtask

  task automatic test_write_with_accept;
    int lat;
    logic od, oe, rb, pb;
    // Same-edge rewrite of the HALT to read input cell 0 instead of cell 28.
    run_vector(8'h01, 1'b1, 21, mk(2, 0, 0, 0), lat, od, oe, rb, pb);
    prog[21] = mk(2, 0, 0, 0);
    n_cmp++;
    if (lat != 24 || od !== 1'b1 || oe !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_with_accept: got lat=%0d data=%b err=%b, expected lat=24 data=1 err=0", lat, od, oe);
    end
    write_instr(21, mk(2, 0, 28, 0));
  endtask

  task automatic test_random;
    int lat, exp_lat, r;
    logic od, oe, rb, pb, exp_d, exp_e;
    logic [7:0] din;
    for (int it = 0; it < 30; it++) begin
      if (it < 8) begin
        if (it == 0) load_rd84();
        din = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      end else begin
        for (int p = 0; p < PROG_DEPTH; p++) begin
          r = int'($urandom_range(0, 15));
          prog[p] = mk((r < 7) ? 0 : (r < 12) ? 1 : (r == 12) ? 2 : 3,
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)));
        end
        write_all();
        din = 8'($urandom);
      end
      model(din, exp_d, exp_e, exp_lat);
      run_vector(din, 1'b0, 0, '0, lat, od, oe, rb, pb);
      n_cmp++;
      if (lat != exp_lat || od !== exp_d || oe !== exp_e || rb !== 1'b0 || pb !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL random it=%0d in=%h: got lat=%0d data=%b err=%b rdy_in_run=%b post=%b, expected lat=%0d data=%b err=%b rdy_in_run=0 post=0",
                 it, din, lat, od, oe, rb, pb, exp_lat, exp_d, exp_e);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_rd84f3();
    test_back_to_back();
    test_backpressure();
    test_write_with_accept();
    test_runaway();
    test_magic_init();
    test_reset_mid();
    test_prog_guard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/magic_nor_sequencer.md
Name: magic_nor_sequencer

Overview:
Sequential executor that evaluates a NOR-only netlist (e.g. the rd84 family of NOR-mapped benchmarks) the way a MAGIC memristor row would: one NOR/NOT micro-op per cycle over a bank of 1-bit cells.
- Downstream consumer of our NOR-mapping flow: a gate-level netlist is compiled to a micro-op program, loaded through the prog port, then run per input vector.
- Input vectors and results move over valid/ready handshakes.

Parameters:
NUM_IN, 8, number of primary-input bits, loaded into cells 0..NUM_IN-1
NUM_CELLS, 32, cell count (power of 2, >= NUM_IN+1); CW = log2(NUM_CELLS)
PROG_DEPTH, 32, program memory depth (power of 2); PW = log2(PROG_DEPTH)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
prog_we  in  1  program write strobe, honoured only in IDLE
prog_addr  in  PW  program write address
prog_data  in  2+3*CW  instruction {op[1:0], dst, srcA, srcB}
in_valid  in  1  input vector valid
in_ready  out  1  high only in IDLE
in_data  in  NUM_IN  input vector; bit i goes to cell i
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  1  result bit
out_err  out  1  program ran off PROG_DEPTH without HALT
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, pc=0, all cells=1, out_valid=0, out_data=0, out_err=0, busy=0, in_ready=1.
- Program memory has no reset, so contents survive rst.
- Ops:
  - 00 NOR2: cell[dst] <= cell[dst] & ~(cell[srcA] | cell[srcB]). This is MAGIC semantics: the cell can only switch 1->0, so dst must still be at its init value 1 to hold a true NOR.
  - 01 NOT: same as NOR2 with srcB ignored.
  - 10 HALT: result <= cell[srcA].
  - 11 NOP: no change.
- IDLE:
  - in_ready=1.
  - prog_we writes mem[prog_addr]. prog_we outside IDLE is ignored.
  - An in_valid&in_ready edge captures in_data and moves to LOAD.
  - A simultaneous prog_we and accept on the same edge performs both; the write lands before EXEC.
- LOAD (1 cycle): cells[i] <= in_data[i] for i<NUM_IN; all other cells <= 1; pc <= 0; then EXEC.
- EXEC:
  - One instruction per cycle; pc increments by 1.
  - The instruction is read combinationally from mem[pc], and the cell update commits at the edge.
  - HALT: out_data <= cell[srcA], out_err <= 0, go to DONE.
  - Non-HALT at pc=PROG_DEPTH-1: out_data <= 0, out_err <= 1, go to DONE. pc does not wrap.
- Write-then-read: an instruction sees cell values from all earlier instructions. Self-reference (dst == srcA) uses the pre-update value.
- Writes to input cells (dst < NUM_IN) are legal and follow the same AND rule.
- DONE:
  - out_valid=1; out_data and out_err are held stable until out_valid&out_ready.
  - Then go to IDLE with out_valid=0.
  - If out_ready=1 on DONE entry, out_valid is high exactly one cycle.
- Latency: for a program of n gate ops followed by HALT, out_valid rises n+3 cycles after the accepting edge (accept edge -> LOAD -> n+1 EXEC cycles -> DONE). Throughput is one vector per n+4 cycles at best.
- Reset mid-operation: async return to reset values; any in-flight vector is dropped with no out_valid.

Decomposition:
- Package magic_pkg holds:
  - op_e enum (NOR2, NOT, HALT, NOP)
  - instr_t packed struct {op, dst, srcA, srcB}
  - state_e (IDLE, LOAD, EXEC, DONE)
  - width localparam functions
- Sub-module magic_prog_mem: PROG_DEPTH x instr_t, synchronous write, asynchronous read, no reset.
- Everything else (FSM, cell bank, pc) lives in magic_nor_sequencer.

Test Plan:
- rd84f3 all-ones: load the compiled 21-op rd84f3 NOR program (8 input NOTs, 4 NOR2, 4 NOT, 2 NOR2, 2 NOT, final NOR2 into cell 28) with HALT srcA=28. Send in_data=0xFF -> out_data=1, out_err=0, out_valid 24 cycles after accept.
- rd84f3 near-miss: in_data=0xFE, then 0x7F, then 0x00 -> out_data=0 each time; in_ready low for the whole run, high again the cycle after the out handshake.
- Backpressure: out_ready held low 10 cycles in DONE -> out_valid and out_data stable; in_valid ignored (in_ready=0); release -> exactly one transfer.
- Runaway program: memory full of NOPs -> out_err=1, out_data=0, out_valid at accept+PROG_DEPTH+2 cycles.
- MAGIC init rule: NOR2 dst=9 with both sources 0, then a second NOR2 to dst=9 with srcA=srcB=0 -> cell 9 stays 1. NOR2 dst=9 with a source 1 -> 0, and a later all-zero NOR cannot restore it (HALT reads 0).
- Reset and programming guard: assert rst at pc=5 -> out_valid never rises, busy=0 immediately, program intact (rerun gives correct result). prog_we during EXEC -> memory unchanged.
